// File: rtl/fir_cap_pkg.sv
// Shared definitions for the filter output capture block: sample format
// defaults (common with filter_6dsp) and the capture state encoding.
package fir_cap_pkg;

  localparam int FIR_DATA_W = 11;
  localparam int FIR_DEPTH  = 128;
  localparam int FIR_ADDR_W = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SKIP = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // A capture is in progress while discarding or storing samples.
  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_SKIP) || (st == ST_CAPT);
  endfunction

endpackage

// File: rtl/fir_cap_ram.sv
// Capture buffer: one write port and one registered read-first read port.
// The array itself is never reset so it maps onto block RAM; only the read
// register is cleared.
module fir_cap_ram #(
  parameter int DATA_W = 11,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              sclr_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];
  logic [DATA_W-1:0] rd_data_r;

  // Sample write; no reset so the contents survive a block reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read; a same-address write in this cycle is not yet visible.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fir_out_capture.sv
// Sink-side capture of the filter output stream: flushes a programmable
// number of samples, then stores a programmable number into a buffer while
// tracking the largest magnitude seen. The buffer is read back afterwards.
module fir_out_capture
  import fir_cap_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_DEPTH,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              sclr_n,
  input  logic              ce,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] filter_out,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        skip_len,
  input  logic [ADDR_W:0]   cap_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] peak_abs,
  output logic              start_err
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  // Magnitude one bit wider than the sample so the most negative value fits.
  function automatic logic [DATA_W:0] abs_ext(input logic [DATA_W-1:0] x);
    logic [DATA_W:0] e;
    e = {x[DATA_W-1], x};
    return x[DATA_W-1] ? (~e + {{DATA_W{1'b0}}, 1'b1}) : e;
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        state_nx_s;
  logic              busy_r;
  logic              done_r;
  logic              start_err_r;
  logic [7:0]        skip_cnt_r;
  logic [ADDR_W:0]   cap_lim_r;
  logic [ADDR_W:0]   count_r;
  logic [DATA_W-1:0] peak_r;

  logic              accept_s;
  logic              start_ok_s;
  logic              start_bad_s;
  logic              wr_en_s;
  logic              skip_dec_s;
  logic [ADDR_W:0]   count_inc_s;
  logic [ADDR_W:0]   cap_lim_s;
  logic [DATA_W:0]   sample_abs_s;

  assign accept_s     = sample_en & ce;
  assign start_ok_s   = start & ~abort & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign start_bad_s  = start & ~abort & is_busy(state_r);
  assign wr_en_s      = accept_s & ~abort & (state_r == ST_CAPT);
  assign skip_dec_s   = accept_s & ~abort & (state_r == ST_SKIP);
  assign count_inc_s  = count_r + {{ADDR_W{1'b0}}, 1'b1};
  assign sample_abs_s = abs_ext(filter_out);
  assign cap_lim_s    = ((cap_len == {(ADDR_W + 1){1'b0}}) || (cap_len > DEPTH_V)) ? DEPTH_V : cap_len;

  // Next-state decode; abort overrides every other event.
  always_comb begin
    state_nx_s = state_r;
    if (abort) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nx_s = (skip_len != 8'd0) ? ST_SKIP : ST_CAPT;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_SKIP: begin
          if (accept_s && (skip_cnt_r == 8'd1)) begin
            state_nx_s = ST_CAPT;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_CAPT: begin
          if (accept_s && (count_inc_s == cap_lim_r)) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = state_r;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Capture control, counters and status flags; outputs follow the next state.
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      start_err_r <= 1'b0;
      skip_cnt_r  <= 8'd0;
      cap_lim_r   <= {(ADDR_W + 1){1'b0}};
      count_r     <= {(ADDR_W + 1){1'b0}};
      peak_r      <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      busy_r  <= is_busy(state_nx_s);
      done_r  <= (state_nx_s == ST_DONE);
      if (start_ok_s) begin
        skip_cnt_r  <= skip_len;
        cap_lim_r   <= cap_lim_s;
        count_r     <= {(ADDR_W + 1){1'b0}};
        peak_r      <= {DATA_W{1'b0}};
        start_err_r <= 1'b0;
      end else begin
        if (start_bad_s) begin
          start_err_r <= 1'b1;
        end
        if (skip_dec_s) begin
          skip_cnt_r <= skip_cnt_r - 8'd1;
        end
        if (wr_en_s) begin
          count_r <= count_inc_s;
          if (sample_abs_s > {1'b0, peak_r}) begin
            peak_r <= sample_abs_s[DATA_W-1:0];
          end
        end
      end
    end
  end

  fir_cap_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .sclr_n  (sclr_n),
    .wr_en   (wr_en_s),
    .wr_addr (count_r[ADDR_W-1:0]),
    .wr_data (filter_out),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign count     = count_r;
  assign peak_abs  = peak_r;
  assign start_err = start_err_r;

endmodule

// File: tb/tb_fir_out_capture.sv
// Directed plus randomized bench for fir_out_capture against a behavioural
// capture model (sample list, counters and a shadow buffer).
module tb_fir_out_capture;

  logic        clk = 1'b0;
  logic        sclr_n = 1'b1;
  logic        ce = 1'b1;
  logic        sample_en = 1'b0;
  logic [10:0] filter_out = 11'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  skip_len = 8'd0;
  logic [7:0]  cap_len = 8'd0;
  logic        rd_en = 1'b0;
  logic [6:0]  rd_addr = 7'd0;
  logic [10:0] rd_data;
  logic        busy;
  logic        done;
  logic [7:0]  count;
  logic [10:0] peak_abs;
  logic        start_err;

  int errors = 0;
  int checks = 0;

  // behavioural model
  bit          m_active;
  bit          m_done;
  bit          m_err;
  int          m_skip_left;
  int          m_target;
  int          m_count;
  int          m_peak;
  logic [10:0] m_mem [0:127];
  bit          m_known [0:127];
  logic [10:0] m_rd;
  bit          m_rd_known;

  always #5 clk = ~clk;

  fir_out_capture dut (
    .clk        (clk),
    .sclr_n     (sclr_n),
    .ce         (ce),
    .sample_en  (sample_en),
    .filter_out (filter_out),
    .start      (start),
    .abort      (abort),
    .skip_len   (skip_len),
    .cap_len    (cap_len),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .peak_abs   (peak_abs),
    .start_err  (start_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/busy"}, 32'(busy), 32'(m_active));
    chk({tag, "/done"}, 32'(done), 32'(m_done));
    chk({tag, "/count"}, 32'(count), 32'(m_count));
    chk({tag, "/peak"}, 32'(peak_abs), 32'(m_peak));
    chk({tag, "/err"}, 32'(start_err), 32'(m_err));
    if (m_rd_known) chk({tag, "/rd"}, 32'(rd_data), 32'(m_rd));
  endtask

  function automatic int mag(input logic [10:0] x);
    int v;
    v = int'($signed(x));
    return (v < 0) ? -v : v;
  endfunction

  // Apply the capture rules to the inputs present before the coming edge.
  task automatic model_step();
    bit acc;
    acc = sample_en && ce;
    if (rd_en) begin
      m_rd = m_mem[rd_addr];
      m_rd_known = m_known[rd_addr];
    end
    if (abort) begin
      m_active = 0;
      m_done = 0;
    end else if (start && !m_active) begin
      m_skip_left = int'(skip_len);
      m_target = (cap_len == 8'd0 || int'(cap_len) > 128) ? 128 : int'(cap_len);
      m_count = 0;
      m_peak = 0;
      m_done = 0;
      m_err = 0;
      m_active = 1;
    end else begin
      if (start && m_active) m_err = 1;
      if (acc && m_active) begin
        if (m_skip_left > 0) begin
          m_skip_left--;
        end else begin
          m_mem[m_count] = filter_out;
          m_known[m_count] = 1;
          m_count++;
          if (mag(filter_out) > m_peak) m_peak = mag(filter_out);
          if (m_count == m_target) begin
            m_active = 0;
            m_done = 1;
          end
        end
      end
    end
  endtask

  task automatic cyc(input string tag, input bit s, input logic [10:0] d,
                     input bit st = 1'b0, input bit ab = 1'b0,
                     input bit re = 1'b0, input logic [6:0] ra = 7'd0);
    sample_en = s;
    filter_out = d;
    start = st;
    abort = ab;
    rd_en = re;
    rd_addr = ra;
    model_step();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    sample_en = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    rd_en = 1'b0;
    sclr_n = 1'b0;
    #1;
    m_active = 0;
    m_done = 0;
    m_err = 0;
    m_count = 0;
    m_peak = 0;
    m_rd = 11'd0;
    m_rd_known = 1;
    chk_all(tag);
    @(posedge clk);
    #2;
    sclr_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_known[i] = 0;
    m_rd_known = 0;
    #2;
    do_reset("reset");

    // skip 3, store 4 of a ramp strobed every 4th clock
    skip_len = 8'd3;
    cap_len = 8'd4;
    cyc("ramp_start", 1'b0, 11'd0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      for (int j = 0; j < 3; j++) cyc("ramp_gap", 1'b0, 11'd0);
      cyc("ramp_smp", 1'b1, 11'(k));
    end
    chk("ramp_count", 32'(count), 32'd4);
    chk("ramp_peak", 32'(peak_abs), 32'd7);
    for (int a = 0; a < 4; a++) begin
      cyc("ramp_rd", 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 7'(a));
      chk("ramp_rdval", 32'(rd_data), 32'(a + 4));
    end

    // second start while skipping
    skip_len = 8'd5;
    cap_len = 8'd3;
    cyc("err_start", 1'b0, 11'd0, 1'b1);
    cyc("err_smp", 1'b1, 11'd100);
    cyc("err_restart", 1'b0, 11'd0, 1'b1);
    chk("err_set", 32'(start_err), 32'd1);
    for (int k = 0; k < 8; k++) cyc("err_run", 1'b1, 11'($urandom_range(0, 2047)));
    chk("err_done", 32'(done), 32'd1);
    skip_len = 8'd0;
    cap_len = 8'd2;
    cyc("err_clear", 1'b0, 11'd0, 1'b1);
    chk("err_cleared", 32'(start_err), 32'd0);
    cyc("err_fin0", 1'b1, 11'd5);
    cyc("err_fin1", 1'b1, 11'h7FF);

    // full-depth capture with cap_len=0, 130 samples k-64
    skip_len = 8'd0;
    cap_len = 8'd0;
    cyc("full_start", 1'b0, 11'd0, 1'b1);
    for (int k = 0; k < 130; k++) cyc("full_smp", 1'b1, 11'(k - 64));
    chk("full_count", 32'(count), 32'd128);
    chk("full_peak", 32'(peak_abs), 32'd64);
    cyc("full_rd0", 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 7'd0);
    chk("full_rd0v", 32'(rd_data), 32'h7C0);
    cyc("full_rd127", 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 7'd127);
    chk("full_rd127v", 32'(rd_data), 32'd63);

    // most negative sample
    cap_len = 8'd1;
    cyc("neg_start", 1'b0, 11'd0, 1'b1);
    cyc("neg_smp", 1'b1, 11'h400);
    chk("neg_peak", 32'(peak_abs), 32'h400);
    cyc("neg_rd", 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 7'd0);
    chk("neg_rdv", 32'(rd_data), 32'h400);

    // ce gating and abort racing start inside CAPT
    cap_len = 8'd8;
    cyc("ab_start", 1'b0, 11'd0, 1'b1);
    for (int k = 0; k < 3; k++) cyc("ab_smp", 1'b1, 11'(k * 50 + 9));
    ce = 1'b0;
    cyc("ab_ce0", 1'b1, 11'd77);
    chk("ab_ce0_cnt", 32'(count), 32'd3);
    ce = 1'b1;
    cyc("ab_abort", 1'b1, 11'd88, 1'b1, 1'b1);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_count", 32'(count), 32'd3);
    cyc("ab_idle", 1'b1, 11'd99);

    // reset in the middle of a capture; contents must survive
    cap_len = 8'd20;
    cyc("mid_start", 1'b0, 11'd0, 1'b1);
    for (int k = 0; k < 5; k++) cyc("mid_smp", 1'b1, 11'($urandom_range(0, 2047)));
    do_reset("mid_reset");
    for (int a = 0; a < 5; a++) cyc("mid_rd", 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 7'(a));

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      ce = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) begin
        skip_len = 8'($urandom_range(0, 6));
        cap_len = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 10)) : 8'($urandom_range(0, 255));
      end
      cyc("rand", 1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
          1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 96) == 0),
          1'($urandom_range(0, 2) == 0), 7'($urandom_range(0, 127)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
